// File: rtl/shot_ctrl.sv
// Fire controller: debounces the fire button, latches the shot origin and sequences ARM/FLIGHT/COOLDOWN.
// Latency: 2-flop sync + DEBOUNCE_CYC stable cycles to accept a press; outputs are registered, 1 cycle after the deciding edge.
// Backpressure: none; fire requests outside IDLE are dropped, hit_in outside FLIGHT is ignored.
//
// Ports:
//   s_clk, rst_n          : clock, asynchronous active-low reset
//   fire_btn              : raw asynchronous fire button (active high)
//   move_tick             : one-cycle motion strobe, shot moves 1 px per strobe
//   ship_x, ship_y        : ship left / top edge, sampled when a shot is fired
//   hit_in                : one-cycle collision pulse, retires the shot in FLIGHT
//   shot_en               : renderer enable (low = renderer loads origin)
//   orig_x, orig_y        : latched spawn origin
//   busy                  : high in ARM, FLIGHT or COOLDOWN
//   shot_count            : shots fired, wraps at 2^16
// Optional feature macro: SHOT_AUTOFIRE_EN (a held accepted button level fires repeatedly from IDLE).
module shot_ctrl #(
    parameter int DEBOUNCE_CYC   = 250000,
    parameter int SHOT_OFS_X     = 17,
    parameter int SHOT_OFS_Y     = 20,
    parameter int COOLDOWN_TICKS = 30
) (
    input  logic        s_clk,
    input  logic        rst_n,
    input  logic        fire_btn,
    input  logic        move_tick,
    input  logic [10:0] ship_x,
    input  logic [10:0] ship_y,
    input  logic        hit_in,
    output logic        shot_en,
    output logic [10:0] orig_x,
    output logic [10:0] orig_y,
    output logic        busy,
    output logic [15:0] shot_count
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam int              CD_W    = (COOLDOWN_TICKS < 1) ? 1 : $clog2(COOLDOWN_TICKS + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_TICKS);
    localparam logic [10:0]     OFS_X   = 11'(SHOT_OFS_X);
    localparam logic [10:0]     OFS_Y   = 11'(SHOT_OFS_Y);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARM      = 2'd1,
        ST_FLIGHT   = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    // Button path state
    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_db_lvl;
    logic            r_db_lvl_d;

    // Shot sequencing state
    state_t          r_state;
    logic [10:0]     r_flight_cnt;
    logic [CD_W-1:0] r_cd_cnt;
    logic            r_shot_en;
    logic [10:0]     r_orig_x;
    logic [10:0]     r_orig_y;
    logic            r_busy;
    logic [15:0]     r_shot_count;

    logic            w_fire_req;
    logic [10:0]     w_spawn_y;
    logic            w_retire;

    // The counter only runs while the synced level disagrees with the accepted
    // level, so any bounce back to the accepted level restarts the count.
    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_cnt   <= '0;
            r_db_lvl   <= 1'b0;
            r_db_lvl_d <= 1'b0;
        end else begin
            r_sync1    <= fire_btn;
            r_sync2    <= r_sync1;
            r_db_lvl_d <= r_db_lvl;
            if (r_sync2 == r_db_lvl) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_lvl <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

`ifdef SHOT_AUTOFIRE_EN
    // Held button keeps requesting; the FSM only listens in IDLE, which paces the shots.
    assign w_fire_req = r_db_lvl;
`else
    assign w_fire_req = r_db_lvl & ~r_db_lvl_d;
`endif

    assign w_spawn_y = (ship_y < OFS_Y) ? 11'd0 : (ship_y - OFS_Y);

    // A hit and the final tick in the same cycle collapse into this single term.
    assign w_retire  = hit_in | (move_tick & (r_flight_cnt == 11'd0));

    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_flight_cnt <= '0;
            r_cd_cnt     <= '0;
            r_shot_en    <= 1'b0;
            r_orig_x     <= '0;
            r_orig_y     <= '0;
            r_busy       <= 1'b0;
            r_shot_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_shot_en <= 1'b0;
                    if (w_fire_req) begin
                        r_orig_x     <= ship_x + OFS_X;
                        r_orig_y     <= w_spawn_y;
                        r_shot_count <= r_shot_count + 16'd1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    // Enable rises only after a motion edge has seen it low,
                    // so the renderer has already loaded the origin.
                    if (move_tick) begin
                        r_flight_cnt <= r_orig_y;
                        r_shot_en    <= 1'b1;
                        r_state      <= ST_FLIGHT;
                    end
                end
                ST_FLIGHT: begin
                    if (w_retire) begin
                        r_shot_en <= 1'b0;
                        r_cd_cnt  <= CD_LOAD;
                        if (COOLDOWN_TICKS == 0) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_COOLDOWN;
                        end
                    end else if (move_tick) begin
                        r_flight_cnt <= r_flight_cnt - 11'd1;
                    end
                end
                ST_COOLDOWN: begin
                    r_shot_en <= 1'b0;
                    if (move_tick) begin
                        if (r_cd_cnt <= CD_W'(1)) begin
                            r_cd_cnt <= '0;
                            r_busy   <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_cd_cnt <= r_cd_cnt - CD_W'(1);
                        end
                    end
                end
                default: begin
                    r_shot_en <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign shot_en    = r_shot_en;
    assign orig_x     = r_orig_x;
    assign orig_y     = r_orig_y;
    assign busy       = r_busy;
    assign shot_count = r_shot_count;

endmodule

// File: tb/tb_shot_ctrl.sv
// Bench for shot_ctrl: directed corner sequences, a spawn-origin vector table,
// and randomized stimulus checked every cycle against a tick-counting reference model.
module tb_shot_ctrl;

    localparam int D    = 4;
    localparam int OFSX = 17;
    localparam int OFSY = 20;
    localparam int CD   = 2;

    logic        s_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fire_btn = 1'b0;
    logic        move_tick = 1'b0;
    logic [10:0] ship_x = '0;
    logic [10:0] ship_y = '0;
    logic        hit_in = 1'b0;
    logic        shot_en;
    logic [10:0] orig_x;
    logic [10:0] orig_y;
    logic        busy;
    logic [15:0] shot_count;

    int n_chk  = 0;
    int n_fail = 0;

    shot_ctrl #(
        .DEBOUNCE_CYC  (D),
        .SHOT_OFS_X    (OFSX),
        .SHOT_OFS_Y    (OFSY),
        .COOLDOWN_TICKS(CD)
    ) dut (
        .s_clk     (s_clk),
        .rst_n     (rst_n),
        .fire_btn  (fire_btn),
        .move_tick (move_tick),
        .ship_x    (ship_x),
        .ship_y    (ship_y),
        .hit_in    (hit_in),
        .shot_en   (shot_en),
        .orig_x    (orig_x),
        .orig_y    (orig_y),
        .busy      (busy),
        .shot_count(shot_count)
    );

    always #5 s_clk = ~s_clk;

    // ---------------- reference model ----------------
    // Button: history of raw samples; the synchroniser is a 2-sample delay and the
    // accepted level flips once D consecutive delayed samples all differ from it.
    // Shot: counts move_ticks since fire; enable is on from tick 1 until retirement,
    // retirement happens at tick orig_y+2 or on a hit, then CD ticks of cooldown.
    bit hist[$];
    bit m_acc, m_acc_prev;
    bit m_busy, m_retired;
    int m_t, m_cd, m_ox, m_oy, m_cnt;

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
        m_acc = 0; m_acc_prev = 0;
        m_busy = 0; m_retired = 0;
        m_t = 0; m_cd = 0; m_ox = 0; m_oy = 0; m_cnt = 0;
    endfunction

    function automatic void model_edge();
        bit req;
        bit flip;
`ifdef SHOT_AUTOFIRE_EN
        req = m_acc;
`else
        req = m_acc && !m_acc_prev;
`endif
        if (!m_busy) begin
            if (req) begin
                m_busy    = 1;
                m_retired = 0;
                m_t       = 0;
                m_ox      = (int'(ship_x) + OFSX) % 2048;
                m_oy      = (int'(ship_y) < OFSY) ? 0 : int'(ship_y) - OFSY;
                m_cnt     = (m_cnt + 1) % 65536;
            end
        end else if (!m_retired) begin
            if (m_t >= 1 && (hit_in || (move_tick && m_t == m_oy + 1))) begin
                m_retired = 1;
                m_cd      = CD;
                if (m_cd == 0) m_busy = 0;
            end else if (move_tick) begin
                m_t++;
            end
        end else if (move_tick) begin
            m_cd--;
            if (m_cd == 0) m_busy = 0;
        end
        hist.push_back(fire_btn);
        if (hist.size() > D + 2) void'(hist.pop_front());
        flip = 1;
        for (int i = 0; i < D; i++) if (hist[i] == m_acc) flip = 0;
        m_acc_prev = m_acc;
        if (flip) m_acc = !m_acc;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("m_shot_en", 32'(shot_en), 32'(m_busy && !m_retired && m_t >= 1));
        chk("m_busy", 32'(busy), 32'(m_busy));
        chk("m_shot_count", 32'(shot_count), 32'(m_cnt));
        chk("m_orig_x", 32'(orig_x), 32'(m_ox));
        chk("m_orig_y", 32'(orig_y), 32'(m_oy));
    endtask

    task automatic step(input bit tk, input bit ht);
        move_tick = tk;
        hit_in    = ht;
        @(posedge s_clk);
        model_edge();
        #1;
        move_tick = 1'b0;
        hit_in    = 1'b0;
        cmp_model();
    endtask

    task automatic press_fire();
        fire_btn = 1'b1;
        repeat (10) step(0, 0);
        fire_btn = 1'b0;
        repeat (10) step(0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 5000) begin
            step(1, 0);
            n++;
        end
        chk("drain_to_idle", 32'(busy), 32'd0);
    endtask

    typedef struct {
        int sx;
        int sy;
        int ex;
        int ey;
    } spawn_vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        spawn_vec_t tbl[6];
        int c0;
        int hold;

        tbl[0] = '{100, 440, 117, 420};
        tbl[1] = '{100, 10, 117, 0};
        tbl[2] = '{2040, 30, 9, 10};
        tbl[3] = '{0, 20, 17, 0};
        tbl[4] = '{5, 19, 22, 0};
        tbl[5] = '{2047, 25, 16, 5};

        model_reset();
        #23;
        chk("reset_shot_en", 32'(shot_en), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_count", 32'(shot_count), 32'd0);
        chk("reset_orig_x", 32'(orig_x), 32'd0);
        chk("reset_orig_y", 32'(orig_y), 32'd0);
        rst_n = 1'b1;

        // Debounce: a 3-cycle glitch is rejected, a long press fires exactly once.
        ship_x = 11'd100;
        ship_y = 11'd440;
        fire_btn = 1'b1;
        repeat (3) step(0, 0);
        fire_btn = 1'b0;
        repeat (12) step(0, 0);
        chk("glitch_count", 32'(shot_count), 32'd0);
        chk("glitch_busy", 32'(busy), 32'd0);
        press_fire();
        chk("press_count", 32'(shot_count), 32'd1);
        chk("press_busy", 32'(busy), 32'd1);
        drain();

        // Spawn origin table, including wrap of X and clamp of Y.
        for (int i = 0; i < 6; i++) begin
            c0 = int'(shot_count);
            ship_x = 11'(tbl[i].sx);
            ship_y = 11'(tbl[i].sy);
            press_fire();
            chk("tbl_orig_x", 32'(orig_x), 32'(tbl[i].ex));
            chk("tbl_orig_y", 32'(orig_y), 32'(tbl[i].ey));
            chk("tbl_count", 32'(shot_count), 32'(c0 + 1));
            ship_x = 11'd500;
            ship_y = 11'd5;
            step(1, 0);
            chk("tbl_orig_hold_x", 32'(orig_x), 32'(tbl[i].ex));
            drain();
        end

        // Full flight with orig_y = 3.
        ship_x = 11'd50;
        ship_y = 11'd23;
        press_fire();
        chk("flt_arm_en", 32'(shot_en), 32'd0);
        step(1, 0);
        chk("flt_en_rise", 32'(shot_en), 32'd1);
        step(0, 0);
        chk("flt_en_idle_cyc", 32'(shot_en), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(1, 0);
            chk("flt_en_during", 32'(shot_en), 32'd1);
        end
        step(1, 0);
        chk("flt_en_fall", 32'(shot_en), 32'd0);
        chk("flt_busy_cd", 32'(busy), 32'd1);
        step(1, 0);
        chk("flt_cd1_busy", 32'(busy), 32'd1);
        step(0, 0);
        chk("flt_cd_wait", 32'(busy), 32'd1);
        step(1, 0);
        chk("flt_idle", 32'(busy), 32'd0);

        // Hit mid-flight, then hit coincident with the final tick.
        press_fire();
        step(1, 0);
        step(0, 1);
        chk("hit_en_off", 32'(shot_en), 32'd0);
        chk("hit_busy", 32'(busy), 32'd1);
        step(1, 0);
        step(1, 0);
        chk("hit_cd_done", 32'(busy), 32'd0);
        step(0, 1);
        chk("hit_idle_ignored", 32'(busy), 32'd0);
        press_fire();
        repeat (4) step(1, 0);
        chk("coinc_pre_en", 32'(shot_en), 32'd1);
        step(1, 1);
        chk("coinc_en_off", 32'(shot_en), 32'd0);
        step(1, 0);
        chk("coinc_cd_once", 32'(busy), 32'd1);
        step(1, 0);
        chk("coinc_idle", 32'(busy), 32'd0);

        // Press during cooldown: dropped; with autofire a held button refires at once.
        press_fire();
        step(1, 0);
        step(0, 1);
        c0 = int'(shot_count);
        fire_btn = 1'b1;
        repeat (10) step(0, 0);
        chk("cd_press_count", 32'(shot_count), 32'(c0));
        chk("cd_press_busy", 32'(busy), 32'd1);
        step(1, 0);
        step(1, 0);
        chk("cd_end_idle", 32'(busy), 32'd0);
        step(0, 0);
`ifdef SHOT_AUTOFIRE_EN
        chk("auto_refire_busy", 32'(busy), 32'd1);
        chk("auto_refire_count", 32'(shot_count), 32'(c0 + 1));
`else
        chk("no_refire_busy", 32'(busy), 32'd0);
        chk("no_refire_count", 32'(shot_count), 32'(c0));
`endif
        fire_btn = 1'b0;
        repeat (10) step(0, 0);
        drain();

        // Asynchronous reset mid-flight, off the clock edge.
        ship_y = 11'd60;
        press_fire();
        repeat (3) step(1, 0);
        chk("rst_pre_en", 32'(shot_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_en", 32'(shot_en), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_count", 32'(shot_count), 32'd0);
        model_reset();
        #10;
        rst_n = 1'b1;
        repeat (3) step(1, 0);
        chk("rst_after_busy", 32'(busy), 32'd0);

        // Randomized traffic against the model.
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                fire_btn = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 12));
            end
            hold--;
            if ($urandom_range(0, 31) == 0) begin
                ship_x = 11'($urandom_range(0, 2047));
                ship_y = 11'($urandom_range(0, 60));
            end
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shot_ctrl.md
Name: shot_ctrl

Overview:
Fire controller that sits directly upstream of the player shot renderer. It debounces the fire button, latches the spawn origin from the ship position, and drives the renderer's enable, origin X and origin Y inputs. It retires the shot when the shot reaches the top of the screen or a hit is reported, then enforces a cooldown before the next shot. All logic runs in the s_clk domain. Shot motion is paced by a one-cycle move_tick strobe, which is the same cadence as the renderer's motion clock.

Parameters:
DEBOUNCE_CYC, 250000, number of stable s_clk cycles before a button level is accepted (10 ms at 25 MHz)
SHOT_OFS_X, 17, X offset added to ship_x to centre the 6-px shot on the 40-px ship
SHOT_OFS_Y, 20, shot length; spawn Y is ship_y minus SHOT_OFS_Y
COOLDOWN_TICKS, 30, number of move_tick strobes between retire and the next allowed fire

Ports:
s_clk  in  1  system pixel clock; the only clock
rst_n  in  1  asynchronous, active-low reset
fire_btn  in  1  raw, asynchronous fire button (active high)
move_tick  in  1  one-cycle strobe; shot advances 1 px per strobe
ship_x  in  11  ship left edge
ship_y  in  11  ship top edge
hit_in  in  1  one-cycle pulse from collision logic: the shot struck an enemy
shot_en  out  1  enable to the renderer; low means load origin
orig_x  out  11  shot spawn X
orig_y  out  11  shot spawn Y
busy  out  1  high in ARM, FLIGHT or COOLDOWN
shot_count  out  16  total shots fired; wraps modulo 2^16

Behaviour:
- Reset (asynchronous, while rst_n is low):
  - state is IDLE.
  - shot_en, orig_x, orig_y, busy and shot_count are all 0.
  - Synchroniser, debounce counter and flight/cooldown counters are cleared.
  - This holds mid-flight as well: the shot vanishes immediately because shot_en drops.
- Button path:
  - 2-flop synchroniser.
  - Debounce counter: it restarts on any change of the synced level; the accepted level updates after DEBOUNCE_CYC stable cycles.
  - fire_req is a one-cycle pulse on the rising edge of the accepted level.
- IDLE:
  - shot_en=0, busy=0.
  - On fire_req, latch orig_x = ship_x + SHOT_OFS_X, truncated to 11 bits.
  - Latch orig_y = ship_y - SHOT_OFS_Y, clamped to 0 if ship_y < SHOT_OFS_Y.
  - Increment shot_count, then go to ARM.
- ARM:
  - shot_en=0; orig_x and orig_y are held.
  - On the first move_tick, load flight_cnt = orig_y and go to FLIGHT.
  - shot_en goes high on the cycle after that move_tick. This guarantees the renderer saw en low on a motion edge, so its origin is loaded.
- FLIGHT:
  - shot_en=1.
  - Each move_tick with flight_cnt > 0 decrements flight_cnt.
  - A move_tick with flight_cnt == 0 retires the shot, so the shot stays visible at y=0 for one tick.
  - hit_in retires the shot.
  - On retire: shot_en=0 on the next cycle, cooldown counter = COOLDOWN_TICKS, go to COOLDOWN.
  - hit_in and a final move_tick in the same cycle produce a single retire.
- COOLDOWN:
  - shot_en=0.
  - Each move_tick decrements the cooldown counter; reaching 0 goes to IDLE.
  - With COOLDOWN_TICKS=0, go straight from retire to IDLE.
- fire_req outside IDLE is dropped, not queued.
- hit_in outside FLIGHT is ignored.
- orig_x and orig_y change only in IDLE on fire_req.

Optional Feature:
SHOT_AUTOFIRE_EN
- Defined: in IDLE, an accepted button level that is held high acts as fire_req. Holding the button fires repeatedly, paced by flight time plus cooldown.
- Undefined: only a rising edge fires; the button must be released and re-pressed between shots.

Test Plan:
1. Reset: rst_n low mid-FLIGHT, asynchronously and not aligned to s_clk -> shot_en=0, busy=0, shot_count=0 immediately, without waiting for an s_clk edge; state IDLE after release.
2. Debounce: DEBOUNCE_CYC=4; fire_btn glitch high for 3 cycles -> no fire; high for 10 cycles -> exactly one fire, shot_count=1.
3. Spawn/clamp: ship_x=100, ship_y=440 -> orig_x=117, orig_y=420; ship_y=10 -> orig_y=0.
4. Full flight: orig_y=3, COOLDOWN_TICKS=2 -> shot_en rises the cycle after the 1st move_tick; falls the cycle after the 5th move_tick (3 decrements plus the final tick); back to IDLE after 2 more ticks.
5. Hit: hit_in during FLIGHT -> shot_en=0 the next cycle; hit_in coincident with the final move_tick -> one retire, cooldown loaded once.
6. Press during COOLDOWN -> ignored, shot_count unchanged. With SHOT_AUTOFIRE_EN and the button held -> second fire in the first IDLE cycle after cooldown.
